// File: rtl/noc_arb_pkg.sv
// Shared NoC arbitration types: flit type codes and arbiter state encodings.
package noc_arb_pkg;

  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;
  localparam logic [2:0] FLIT_HT     = 3'b101;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr wins.
module rr_pick #(
  parameter int  NUM_PORTS = 5,
  localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] win,
  output logic                 any
);

  int j;

  // Walk from the farthest offset down so the closest requester to ptr wins.
  always_comb begin
    win = '0;
    j   = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_PORTS;
      if (req[j]) begin
        win    = '0;
        win[j] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin output-port arbiter with wormhole lock and zero-bubble re-arbitration.
// Optional: define ARB_LEN_COUNT_EN to also release on the packet's flit count.
module rr_packet_arbiter
  import noc_arb_pkg::*;
#(
  parameter int  NUM_PORTS = 5,
  parameter int  LEN_W     = 12,
  parameter int  FLIT_ID_W = 3,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS*FLIT_ID_W-1:0] flit_id,
  input  logic [NUM_PORTS*LEN_W-1:0]     length,
  input  logic                           out_ready,
  output logic [NUM_PORTS-1:0]           grant,
  output logic                           grant_valid,
  output logic [IDX_W-1:0]               grant_idx,
  output logic                           fire
);

  arb_state_e           state;
  logic [IDX_W-1:0]     ptr, win_idx, nxt_ptr;
  logic [NUM_PORTS-1:0] win;
  logic                 any_req, is_tail, len_done, rel;
  logic [FLIT_ID_W-1:0] cur_id;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any_req)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (win[i]) win_idx = IDX_W'(i);
  end

  assign nxt_ptr     = (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);
  assign grant_valid = |grant;
  assign fire        = grant_valid & req[grant_idx] & out_ready;
  assign cur_id      = flit_id[int'(grant_idx)*FLIT_ID_W +: FLIT_ID_W];
  assign is_tail     = (cur_id == FLIT_ID_W'(FLIT_TAIL)) || (cur_id == FLIT_ID_W'(FLIT_HT));
  assign rel         = fire & (is_tail | len_done);

`ifdef ARB_LEN_COUNT_EN
  logic [LEN_W-1:0] cnt, cur_len, eff_len;
  logic             is_hdr;

  assign cur_len  = length[int'(grant_idx)*LEN_W +: LEN_W];
  assign eff_len  = (cur_len == '0) ? LEN_W'(1) : cur_len;
  assign is_hdr   = (cur_id == FLIT_ID_W'(FLIT_HEADER));
  // The header fire counts as the first flit, so compare its length directly.
  assign len_done = is_hdr ? (eff_len == LEN_W'(1)) : (cnt == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst || rel)        cnt <= '0;
    else if (fire) begin
      if (is_hdr)          cnt <= eff_len - LEN_W'(1);
      else if (cnt != '0)  cnt <= cnt - LEN_W'(1);
    end
  end
`else
  logic unused_len;
  assign unused_len = ^length;
  assign len_done   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        ARB_IDLE:
          if (any_req) begin
            state     <= ARB_LOCKED;
            grant     <= win;
            grant_idx <= win_idx;
            ptr       <= nxt_ptr;
          end
        ARB_LOCKED:
          // ptr already points past the holder, so the released port ranks last.
          if (rel) begin
            if (any_req) begin
              grant     <= win;
              grant_idx <= win_idx;
              ptr       <= nxt_ptr;
            end else begin
              state     <= ARB_IDLE;
              grant     <= '0;
              grant_idx <= '0;
            end
          end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Scoreboard bench for rr_packet_arbiter: expected grants queued at stimulus, checked at grant.
module tb_rr_packet_arbiter;
  import noc_arb_pkg::*;

  localparam int NP = 5, LW = 12, FW = 3, IW = 3;

  logic           clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
  logic [NP-1:0]  req = '0;
  logic [NP*FW-1:0] flit_id = '0;
  logic [NP*LW-1:0] length = '0;
  logic [NP-1:0]  grant;
  logic           grant_valid, fire;
  logic [IW-1:0]  grant_idx;

  int n_cmp = 0, n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  rr_packet_arbiter #(.NUM_PORTS(NP), .LEN_W(LW), .FLIT_ID_W(FW)) dut (
    .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
    .out_ready(out_ready), .grant(grant), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .fire(fire)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_fid(input int p, input logic [2:0] v);
    flit_id[p*FW +: FW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; out_ready = 1'b0; flit_id = '0; length = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; out_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (grant !== 5'b0) begin n_err++; $display("FAIL reset_grant: got %b want %b", grant, 5'b0); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", grant_valid); end
    n_cmp++; if (grant_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", grant_idx); end
    n_cmp++; if (fire !== 1'b0) begin n_err++; $display("FAIL reset_fire: got %b want 0", fire); end
    n_cmp++; if (dut.ptr !== 3'd0) begin n_err++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr); end
    rst = 1'b0; req = '0; out_ready = 1'b0;
  endtask

  task automatic test_first_grant();
    req = 5'b00110; out_ready = 1'b0;
    exp_q.push_back(1);
    tick();
    n_cmp++; if (grant !== 5'b00010) begin n_err++; $display("FAIL first_grant: got %b want %b", grant, 5'b00010); end
    n_cmp++; if (grant_idx !== 3'(exp_q[0])) begin n_err++; $display("FAIL first_idx: got %0d want %0d", grant_idx, exp_q[0]); end
    void'(exp_q.pop_front());
    n_cmp++; if (dut.ptr !== 3'd2) begin n_err++; $display("FAIL first_ptr: got %0d want 2", dut.ptr); end
    n_cmp++; if (dut.state !== ARB_LOCKED) begin n_err++; $display("FAIL first_state: got %0d want %0d", dut.state, ARB_LOCKED); end
  endtask

  task automatic test_back_to_back();
    int pos[NP];
    int e, bubbles;
    bit started;
    do_reset();
    exp_q = {0, 1, 2, 3, 4, 0};
    foreach (pos[p]) pos[p] = 0;
    bubbles = 0; started = 0;
    req = '1; out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      for (int p = 0; p < NP; p++) set_fid(p, (pos[p] == 0) ? FLIT_HEADER : FLIT_TAIL);
      #1;
      if (grant_valid) begin
        started = 1;
        if (pos[grant_idx] == 0) begin
          e = exp_q.pop_front();
          n_cmp++; if (grant_idx !== 3'(e)) begin n_err++; $display("FAIL b2b_idx: got %0d want %0d", grant_idx, e); end
          n_cmp++; if (grant !== NP'(1 << e)) begin n_err++; $display("FAIL b2b_grant: got %b want %b", grant, NP'(1 << e)); end
        end
        if (fire) pos[grant_idx] = (pos[grant_idx] == 0) ? 1 : 0;
      end else if (started) bubbles++;
      tick();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_timeout: got %0d pending want 0", exp_q.size()); end
    n_cmp++; if (bubbles != 0) begin n_err++; $display("FAIL b2b_bubble: got %0d idle cycles want 0", bubbles); end
    exp_q.delete();
  endtask

  task automatic test_stall();
    int pos, e;
    bit done, exp_fire;
    do_reset();
    req = 5'b00100; out_ready = 1'b0; set_fid(2, FLIT_HEADER);
    exp_q.push_back(2);
    tick();
    req = '1;
    for (int p = 0; p < NP; p++) if (p != 2) set_fid(p, FLIT_HEADER);
    pos = 0; done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      exp_fire  = (k % 2 == 0) && !(k >= 3 && k <= 5);
      out_ready = (k % 2 == 0);
      req[2]    = !(k >= 3 && k <= 5);
      set_fid(2, (pos == 0) ? FLIT_HEADER : (pos == 3) ? FLIT_TAIL : FLIT_BODY);
      #1;
      if (k == 0) begin
        e = exp_q.pop_front();
        n_cmp++; if (grant_idx !== 3'(e)) begin n_err++; $display("FAIL stall_idx: got %0d want %0d", grant_idx, e); end
      end
      n_cmp++; if (grant !== 5'b00100) begin n_err++; $display("FAIL stall_hold k=%0d: got %b want %b", k, grant, 5'b00100); end
      n_cmp++; if (fire !== exp_fire) begin n_err++; $display("FAIL stall_fire k=%0d: got %b want %b", k, fire, exp_fire); end
      if (fire) begin pos++; if (pos == 4) done = 1; end
      tick();
    end
    n_cmp++; if (!done) begin n_err++; $display("FAIL stall_timeout: got %0d flits want 4", pos); end
    n_cmp++; if (grant !== 5'b01000) begin n_err++; $display("FAIL stall_next: got %b want %b", grant, 5'b01000); end
  endtask

  task automatic test_ht_repeat();
    int e;
    do_reset();
    req = 5'b01000; set_fid(3, FLIT_HT); out_ready = 1'b1;
    #1;
    n_cmp++; if (fire !== 1'b0) begin n_err++; $display("FAIL ht_idle_fire: got %b want 0", fire); end
    repeat (3) exp_q.push_back(3);
    tick();
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      n_cmp++; if (grant_idx !== 3'(e)) begin n_err++; $display("FAIL ht_idx k=%0d: got %0d want %0d", k, grant_idx, e); end
      n_cmp++; if (fire !== 1'b1) begin n_err++; $display("FAIL ht_fire k=%0d: got %b want 1", k, fire); end
      tick();
    end
    req = '0;
    #1;
    n_cmp++; if (grant !== 5'b01000) begin n_err++; $display("FAIL ht_hold: got %b want %b", grant, 5'b01000); end
    n_cmp++; if (fire !== 1'b0) begin n_err++; $display("FAIL ht_stall_fire: got %b want 0", fire); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 5'b00010; set_fid(1, FLIT_HEADER); out_ready = 1'b1;
    tick();
    n_cmp++; if (grant !== 5'b00010) begin n_err++; $display("FAIL rmid_lock: got %b want %b", grant, 5'b00010); end
    tick();
    set_fid(1, FLIT_BODY); rst = 1'b1;
    tick();
    n_cmp++; if (grant !== 5'b0) begin n_err++; $display("FAIL rmid_grant: got %b want 0", grant); end
    n_cmp++; if (dut.state !== ARB_IDLE) begin n_err++; $display("FAIL rmid_state: got %0d want %0d", dut.state, ARB_IDLE); end
    rst = 1'b0; req = '1; out_ready = 1'b0;
    for (int p = 0; p < NP; p++) set_fid(p, FLIT_HEADER);
    tick();
    n_cmp++; if (grant !== 5'b00001) begin n_err++; $display("FAIL rmid_regrant: got %b want %b", grant, 5'b00001); end
  endtask

`ifdef ARB_LEN_COUNT_EN
  task automatic test_len_count();
    do_reset();
    req = 5'b00011; out_ready = 1'b1;
    length[0*LW +: LW] = 12'd3; length[1*LW +: LW] = 12'd0;
    set_fid(0, FLIT_HEADER); set_fid(1, FLIT_HEADER);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_fid(0, (k == 0) ? FLIT_HEADER : FLIT_BODY);
      #1;
      n_cmp++; if (grant !== 5'b00001) begin n_err++; $display("FAIL len3_hold k=%0d: got %b want %b", k, grant, 5'b00001); end
      n_cmp++; if (fire !== 1'b1) begin n_err++; $display("FAIL len3_fire k=%0d: got %b want 1", k, fire); end
      tick();
    end
    n_cmp++; if (grant !== 5'b00010) begin n_err++; $display("FAIL len3_release: got %b want %b", grant, 5'b00010); end
    req = 5'b00110; set_fid(2, FLIT_HEADER);
    #1;
    n_cmp++; if (fire !== 1'b1) begin n_err++; $display("FAIL len0_fire: got %b want 1", fire); end
    tick();
    n_cmp++; if (grant !== 5'b00100) begin n_err++; $display("FAIL len0_release: got %b want %b", grant, 5'b00100); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_grant();
    test_back_to_back();
    test_stall();
    test_ht_repeat();
    test_reset_mid();
`ifdef ARB_LEN_COUNT_EN
    test_len_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
